// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the encoder / channel / Viterbi-decoder chain: LOAD, TAIL, DRAIN, DONE.
// Optional bit-error statistics are enabled by defining VIT_BER_STATS_EN.
module viterbi_frame_ctrl #(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned TAIL_LEN  = 2,
    parameter int unsigned DEC_LAT   = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        src_valid_i,
    input  logic        src_data_i,
    output logic        src_ready_o,
    output logic        enc_enable_o,
    output logic        enc_data_o,
    input  logic        dec_data_i,
    output logic        out_valid_o,
    output logic        out_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        underrun_o,
    output logic [15:0] bit_err_cnt_o
);

    localparam int unsigned MaxAb  = (FRAME_LEN > DEC_LAT) ? FRAME_LEN : DEC_LAT;
    localparam int unsigned MaxCnt = (MaxAb > TAIL_LEN) ? MaxAb : TAIL_LEN;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    typedef enum logic [2:0] {StIdle, StLoad, StTail, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                underrun_q, underrun_d;
    logic                src_ready_q, src_ready_d;
    logic                enc_enable_q, enc_enable_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DEC_LAT-1:0]  tag_q, tag_d;
    logic                out_valid_q, out_valid_d;
    logic                out_data_q, out_data_d;
    logic                start_accept;

    assign start_accept = (state_q == StIdle) && start_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        underrun_d = underrun_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StLoad;
                    cnt_d      = '0;
                    underrun_d = 1'b0;
                end
            end
            StLoad: begin
                if (!src_valid_i) underrun_d = 1'b1;
                if (cnt_q == CntW'(FRAME_LEN - 1)) begin
                    state_d = StTail;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StTail: begin
                if (cnt_q == CntW'(TAIL_LEN - 1)) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDrain: begin
                if (cnt_q == CntW'(DEC_LAT - 1)) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they line up with the state register.
        src_ready_d  = (state_d == StLoad);
        enc_enable_d = (state_d == StLoad) || (state_d == StTail) || (state_d == StDrain);
        busy_d       = (state_d != StIdle);
        done_d       = (state_d == StDone);

        tag_d       = {tag_q[DEC_LAT-2:0], src_ready_q};
        out_valid_d = tag_q[DEC_LAT-1];
        out_data_d  = tag_q[DEC_LAT-1] & dec_data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            underrun_q   <= 1'b0;
            src_ready_q  <= 1'b0;
            enc_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tag_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            underrun_q   <= underrun_d;
            src_ready_q  <= src_ready_d;
            enc_enable_q <= enc_enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            tag_q        <= tag_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    // The source bit is passed straight through in the cycle it is consumed.
    assign enc_data_o   = src_ready_q & src_valid_i & src_data_i;
    assign src_ready_o  = src_ready_q;
    assign enc_enable_o = enc_enable_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign underrun_o   = underrun_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;

`ifdef VIT_BER_STATS_EN
    logic [DEC_LAT-1:0] ref_q, ref_d;
    logic               ref_out_q, ref_out_d;
    logic [15:0]        err_cnt_q, err_cnt_d;

    always_comb begin
        ref_d     = {ref_q[DEC_LAT-2:0], enc_data_o};
        ref_out_d = ref_q[DEC_LAT-1];
        err_cnt_d = err_cnt_q;
        if (start_accept) begin
            err_cnt_d = 16'd0;
        end else if (out_valid_q && (out_data_q != ref_out_q) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q     <= '0;
            ref_out_q <= 1'b0;
            err_cnt_q <= 16'd0;
        end else begin
            ref_q     <= ref_d;
            ref_out_q <= ref_out_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bit_err_cnt_o = err_cnt_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
    assign bit_err_cnt_o       = 16'd0;
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Bench for viterbi_frame_ctrl: random frames through an ideal delay channel with injected
// decoded-bit errors; expectations come from per-frame arrays and cycle arithmetic.
module tb_viterbi_frame_ctrl;

    localparam int FL      = 256;
    localparam int TL      = 2;
    localparam int DL      = 20;
    localparam int DoneCyc = FL + TL + DL + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        src_valid_i = 1'b0;
    logic        src_data_i = 1'b0;
    logic        src_ready_o, enc_enable_o, enc_data_o;
    logic        dec_data_i;
    logic        out_valid_o, out_data_o, busy_o, done_o, underrun_o;
    logic [15:0] bit_err_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [DL-1:0] chan_q;
    logic          flip_now = 1'b0;

    viterbi_frame_ctrl #(.FRAME_LEN(FL), .TAIL_LEN(TL), .DEC_LAT(DL)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .src_valid_i  (src_valid_i),
        .src_data_i   (src_data_i),
        .src_ready_o  (src_ready_o),
        .enc_enable_o (enc_enable_o),
        .enc_data_o   (enc_data_o),
        .dec_data_i   (dec_data_i),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .underrun_o   (underrun_o),
        .bit_err_cnt_o(bit_err_cnt_o)
    );

    always #5 clk = ~clk;

    // Ideal chain: decoded bit equals encoder input DL cycles later, optionally flipped.
    always @(posedge clk or posedge rst) begin
        if (rst) chan_q <= '0;
        else     chan_q <= {chan_q[DL-2:0], enc_data_o ^ flip_now};
    end
    assign dec_data_i = chan_q[DL-1];

    // pattern 0: random bits, 1: single one at bit 0. drop/flip ranges inclusive, -1 = none.
    task automatic run_frame(input string name, input int pattern, input int drop_lo,
                             input int drop_hi, input int flip_lo, input int flip_hi,
                             input int start_mid, input bit start_in_done);
        bit raw[FL];
        bit valid[FL];
        bit sent[FL];
        bit flip[FL];
        int nflip = 0;
        int nout  = 0;
        logic [15:0] exp_err;
        logic exp_b;
        for (int i = 0; i < FL; i++) begin
            raw[i]   = (pattern == 0) ? 1'($urandom % 2) : (i == 0);
            valid[i] = !(i >= drop_lo && i <= drop_hi);
            sent[i]  = valid[i] ? raw[i] : 1'b0;
            flip[i]  = (i >= flip_lo && i <= flip_hi);
            if (flip[i]) nflip++;
        end
`ifdef VIT_BER_STATS_EN
        exp_err = 16'(nflip);
`else
        exp_err = 16'd0;
`endif
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        for (int cyc = 1; cyc <= DoneCyc + 2; cyc++) begin
            if (cyc <= FL) begin
                src_valid_i = valid[cyc-1];
                src_data_i  = raw[cyc-1];
                flip_now    = flip[cyc-1];
            end else begin
                src_valid_i = 1'($urandom % 2);
                src_data_i  = 1'($urandom % 2);
                flip_now    = 1'b0;
            end
            start_i = (cyc == start_mid) || (start_in_done && cyc == DoneCyc);
            @(negedge clk);
            checks++;
            if (src_ready_o !== (cyc <= FL)) begin
                errors++;
                $display("FAIL %s src_ready cyc=%0d got=%b exp=%b", name, cyc, src_ready_o,
                         cyc <= FL);
            end
            checks++;
            if (enc_enable_o !== (cyc <= FL + TL + DL)) begin
                errors++;
                $display("FAIL %s enc_enable cyc=%0d got=%b exp=%b", name, cyc, enc_enable_o,
                         cyc <= FL + TL + DL);
            end
            exp_b = (cyc <= FL) ? sent[cyc-1] : 1'b0;
            checks++;
            if (enc_data_o !== exp_b) begin
                errors++;
                $display("FAIL %s enc_data cyc=%0d got=%b exp=%b", name, cyc, enc_data_o, exp_b);
            end
            checks++;
            if (busy_o !== (cyc <= DoneCyc)) begin
                errors++;
                $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, cyc, busy_o,
                         cyc <= DoneCyc);
            end
            checks++;
            if (done_o !== (cyc == DoneCyc)) begin
                errors++;
                $display("FAIL %s done cyc=%0d got=%b exp=%b", name, cyc, done_o,
                         cyc == DoneCyc);
            end
            checks++;
            if (out_valid_o !== (cyc >= DL + 2 && cyc <= FL + DL + 1)) begin
                errors++;
                $display("FAIL %s out_valid cyc=%0d got=%b", name, cyc, out_valid_o);
            end
            exp_b = (cyc >= DL + 2 && cyc <= FL + DL + 1) ?
                    (sent[cyc-DL-2] ^ flip[cyc-DL-2]) : 1'b0;
            checks++;
            if (out_data_o !== exp_b) begin
                errors++;
                $display("FAIL %s out_data cyc=%0d got=%b exp=%b", name, cyc, out_data_o, exp_b);
            end
            if (out_valid_o === 1'b1 && cyc < DoneCyc) nout++;
            if (drop_lo < 0 || cyc <= drop_lo || cyc >= drop_lo + 2) begin
                exp_b = (drop_lo >= 0 && cyc >= drop_lo + 2);
                checks++;
                if (underrun_o !== exp_b) begin
                    errors++;
                    $display("FAIL %s underrun cyc=%0d got=%b exp=%b", name, cyc, underrun_o,
                             exp_b);
                end
            end
            if (cyc == 1 || cyc == DoneCyc) begin
                checks++;
                if (bit_err_cnt_o !== ((cyc == 1) ? 16'd0 : exp_err)) begin
                    errors++;
                    $display("FAIL %s bit_err_cnt cyc=%0d got=%0d exp=%0d", name, cyc,
                             bit_err_cnt_o, (cyc == 1) ? 16'd0 : exp_err);
                end
            end
            @(posedge clk); #1;
        end
        start_i     = 1'b0;
        src_valid_i = 1'b0;
        checks++;
        if (nout != FL) begin
            errors++;
            $display("FAIL %s out_count got=%0d exp=%0d", name, nout, FL);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({src_ready_o, enc_enable_o, enc_data_o, out_valid_o, out_data_o, busy_o, done_o,
             underrun_o, bit_err_cnt_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0", {src_ready_o, enc_enable_o, enc_data_o,
                     out_valid_o, out_data_o, busy_o, done_o, underrun_o, bit_err_cnt_o});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || enc_enable_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b done=%b en=%b exp=000", busy_o, done_o,
                     enc_enable_o);
        end
    endtask

    task automatic test_clean();
        run_frame("clean", 0, -1, -1, -1, -1, -1, 1'b0);
    endtask

    task automatic test_alignment();
        run_frame("align", 1, -1, -1, -1, -1, -1, 1'b0);
    endtask

    task automatic test_underrun();
        run_frame("underrun", 0, 10, 12, -1, -1, -1, 1'b0);
        checks++;
        if (underrun_o !== 1'b1) begin
            errors++;
            $display("FAIL underrun_sticky got=%b exp=1", underrun_o);
        end
        run_frame("underrun_clear", 0, -1, -1, -1, -1, -1, 1'b0);
    endtask

    task automatic test_start_busy();
        run_frame("start_busy", 0, -1, -1, -1, -1, 100, 1'b1);
    endtask

    task automatic test_reset_drain();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        for (int cyc = 1; cyc < 265; cyc++) begin
            src_valid_i = 1'b1;
            src_data_i  = 1'($urandom % 2);
            @(posedge clk); #1;
        end
        src_valid_i = 1'b0;
        checks++;
        if (enc_enable_o !== 1'b1 || src_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL drain_state en=%b rdy=%b busy=%b exp=101", enc_enable_o, src_ready_o,
                     busy_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({src_ready_o, enc_enable_o, enc_data_o, out_valid_o, out_data_o, busy_o, done_o,
             underrun_o, bit_err_cnt_o} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs got=%b exp=0", {src_ready_o, enc_enable_o,
                     enc_data_o, out_valid_o, out_data_o, busy_o, done_o, underrun_o,
                     bit_err_cnt_o});
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle cyc=%0d done=%b busy=%b oval=%b exp=000", cyc,
                         done_o, busy_o, out_valid_o);
            end
        end
        run_frame("after_reset", 0, -1, -1, -1, -1, -1, 1'b0);
    endtask

    task automatic test_stats();
        run_frame("stats", 0, -1, -1, 100, 103, -1, 1'b0);
        run_frame("stats_clear", 0, -1, -1, 0, 3, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_alignment();
        test_underrun();
        test_start_busy();
        test_reset_drain();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
